pipeline_sequencer: RTL
=======================

# pipeline_sequencer

Central controller for the 5-stage pipeline. It produces the per-stage enable and flush strobes for PC, IF/ID, ID/EX and the downstream registers (EX/MEM, MEM/WB). It sequences start, continuous run, debug single-step and halt drain, and detects load-use hazards. It sits beside the datapath and samples hazard and halt information from the ID, EX and WB stages.

## Interface
Parameters:
- NSTAGES, 5: pipeline depth; bounds the halt-drain timeout.
- RBITS, 5: register-name width.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous, active-high reset.
- i_start  in  1  pulse; leaves IDLE.
- i_run_mode  in  1  level: 1 = continuous, 0 = single-step.
- i_step  in  1  pulse; one pipeline advance in STEP.
- ID_rs, ID_rt  in  RBITS  source registers of the instruction in ID.
- EX_rt  in  RBITS  destination of the instruction in EX.
- EX_memread  in  1  instruction in EX is a load.
- i_branch_taken  in  1  branch resolved taken in ID.
- ID_haltflag  in  1  halt instruction in ID.
- WB_haltflag  in  1  halt instruction in WB (MEM/WB output).
- o_pc_en  out  1  PC write enable.
- o_ifid_en  out  1  IF/ID write enable.
- o_ifid_flush  out  1  IF/ID clear.
- o_idex_flush  out  1  ID/EX clear (bubble insert).
- o_pipe_en  out  1  enable for ID/EX, EX/MEM and MEM/WB.
- o_halted  out  1  state == HALTED.
- o_state  out  2  current state.
- o_cycle_count  out  32  advanced-cycle counter.

## Operation
- States, with o_state encoding: IDLE=00, RUN=01, STEP=10, HALTED=11.
- Transitions:
  - IDLE: i_start → RUN if i_run_mode, else STEP.
  - RUN ↔ STEP: follows i_run_mode level, evaluated every cycle.
  - RUN/STEP → HALTED: on WB_haltflag, or when the drain timeout fires. Halt has priority over a mode change.
  - HALTED is sticky until i_rst.
- advance = (state==RUN) | (state==STEP & i_step).
- stall = EX_memread & (EX_rt != 0) & (EX_rt==ID_rs | EX_rt==ID_rt).
- Outputs (combinational):
  - o_pipe_en = advance.
  - o_pc_en = advance & !stall & !fetch_stop & !ID_haltflag.
  - o_ifid_en = advance & !stall.
  - o_idex_flush = advance & stall.
  - o_ifid_flush = advance & !stall & (i_branch_taken | ID_haltflag | fetch_stop).
- Stall beats branch flush. A stalled branch is re-evaluated on the next advance.
- fetch_stop register:
  - Set on advance & ID_haltflag & !stall.
  - Cleared only by reset.
  - Once set, no new instructions enter; downstream stages drain.
- drain_cnt, width $clog2(NSTAGES+1):
  - Increments on each advance while fetch_stop is set.
  - Reaching NSTAGES without WB_haltflag forces HALTED.
- i_step outside STEP is ignored. i_start outside IDLE is ignored.

## Timing
- State, fetch_stop, drain_cnt and the counter are registered. Strobes are Mealy and valid in the same cycle as their inputs.
- Reset values: state IDLE, fetch_stop 0, drain_cnt 0, o_cycle_count 0. All strobes read 0 in IDLE and HALTED.
- Reset mid-operation: returns to IDLE on the next edge and overrides all other events.
- Start latency: i_start at edge N gives the first advance in cycle N+1 (RUN).
- Halt latency: ID_haltflag to HALTED takes 3 advances in a clean pipe (ID→EX→MEM→WB). o_halted rises the edge after WB_haltflag is sampled.
- Step: one i_step pulse produces exactly one cycle with o_pipe_en=1. A held i_step advances every cycle.

## Configuration
- PIPE_CYCLE_COUNT_EN defined:
  - o_cycle_count increments on every advance, saturating at 32'hFFFF_FFFF.
  - Frozen in HALTED; cleared by reset.
- Not defined: o_cycle_count is tied to 0 and no counter register exists.

## Structure
- Package pipe_seq_pkg holds:
  - State localparams ST_IDLE, ST_RUN, ST_STEP, ST_HALTED.
  - State width 2.
  - Default RBITS and NSTAGES.
- Sub-module hazard_detect (combinational load-use compare producing stall) is instantiated once.

## Test plan
- Reset, then i_start with i_run_mode=1 → o_state 01, o_pc_en=o_ifid_en=o_pipe_en=1 from the next cycle.
- RUN with EX_memread=1, EX_rt=5, ID_rs=5 → o_pc_en=0, o_ifid_en=0, o_idex_flush=1 for that cycle. Same with EX_rt=0 → no stall.
- Stall and i_branch_taken=1 together → o_ifid_flush=0, o_idex_flush=1.
- ID_haltflag=1 at cycle N → o_pc_en=0 and o_ifid_flush=1 at N. WB_haltflag=1 at N+3 → o_halted=1 at N+4, all strobes 0. i_start then ignored.
- STEP mode: i_step pulsed 3 times over 10 cycles → exactly 3 cycles with o_pipe_en=1, and o_cycle_count=3 when PIPE_CYCLE_COUNT_EN is defined.
- Halt without WB_haltflag → HALTED after NSTAGES=5 drain advances. i_rst asserted mid-drain → IDLE, fetch_stop 0.

Source files
------------

// File: rtl/pipe_seq_pkg.sv
// Shared definitions for the pipeline sequencer: state encodings, state
// width and the default geometry parameters.
package pipe_seq_pkg;

  localparam int STATE_W     = 2;
  localparam int DEF_RBITS   = 5;
  localparam int DEF_NSTAGES = 5;

  localparam logic [STATE_W-1:0] ST_IDLE   = 2'b00;
  localparam logic [STATE_W-1:0] ST_RUN    = 2'b01;
  localparam logic [STATE_W-1:0] ST_STEP   = 2'b10;
  localparam logic [STATE_W-1:0] ST_HALTED = 2'b11;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare: the load in EX writes a register that the
// instruction in ID reads. Register 0 is hard-wired and never creates a hazard.
module hazard_detect
  import pipe_seq_pkg::*;
#(
  parameter int RBITS = DEF_RBITS
) (
  input  logic             ex_memread,
  input  logic [RBITS-1:0] ex_rt,
  input  logic [RBITS-1:0] id_rs,
  input  logic [RBITS-1:0] id_rt,
  output logic             stall
);

  localparam logic [RBITS-1:0] REG_ZERO = {RBITS{1'b0}};

  // Stall when a load in EX targets a non-zero register read by ID.
  always_comb begin
    stall = ex_memread & (ex_rt != REG_ZERO) & ((ex_rt == id_rs) | (ex_rt == id_rt));
  end

endmodule

// File: rtl/pipeline_sequencer.sv
// Central controller for the 5-stage pipeline: IDLE/RUN/STEP/HALTED
// sequencing, load-use stalls, branch/halt flushes and the halt drain.
// Optional feature macro: PIPE_CYCLE_COUNT_EN (saturating advance counter on
// o_cycle_count; when undefined the output is tied to zero).
module pipeline_sequencer
  import pipe_seq_pkg::*;
#(
  parameter int NSTAGES = DEF_NSTAGES,
  parameter int RBITS   = DEF_RBITS
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic               i_run_mode,
  input  logic               i_step,
  input  logic [RBITS-1:0]   ID_rs,
  input  logic [RBITS-1:0]   ID_rt,
  input  logic [RBITS-1:0]   EX_rt,
  input  logic               EX_memread,
  input  logic               i_branch_taken,
  input  logic               ID_haltflag,
  input  logic               WB_haltflag,
  output logic               o_pc_en,
  output logic               o_ifid_en,
  output logic               o_ifid_flush,
  output logic               o_idex_flush,
  output logic               o_pipe_en,
  output logic               o_halted,
  output logic [STATE_W-1:0] o_state,
  output logic [31:0]        o_cycle_count
);

  localparam int DW = $clog2(NSTAGES + 1);
  localparam logic [DW-1:0] DRAIN_ZERO = {DW{1'b0}};
  localparam logic [DW-1:0] DRAIN_ONE  = DW'(1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(NSTAGES - 1);
  localparam logic [DW-1:0] DRAIN_MAX  = DW'(NSTAGES);

  logic [STATE_W-1:0] state;
  logic [STATE_W-1:0] state_next;
  logic               fetch_stop;
  logic [DW-1:0]      drain_cnt;
  logic               stall;
  logic               advance;
  logic               timeout;

  hazard_detect #(.RBITS(RBITS)) u_hazard (
    .ex_memread (EX_memread),
    .ex_rt      (EX_rt),
    .id_rs      (ID_rs),
    .id_rt      (ID_rt),
    .stall      (stall)
  );

  // State register; reset returns to IDLE regardless of other events.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state: halt (WB flag or drain timeout) beats a run/step mode change.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (i_start) begin
          state_next = i_run_mode ? ST_RUN : ST_STEP;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_RUN, ST_STEP: begin
        if (WB_haltflag | timeout) begin
          state_next = ST_HALTED;
        end else if (i_run_mode) begin
          state_next = ST_RUN;
        end else begin
          state_next = ST_STEP;
        end
      end
      ST_HALTED: state_next = ST_HALTED;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Mealy strobes: every strobe is gated by advance, so IDLE/HALTED read 0.
  always_comb begin
    advance      = (state == ST_RUN) | ((state == ST_STEP) & i_step);
    timeout      = advance & fetch_stop & (drain_cnt == DRAIN_LAST);
    o_pipe_en    = advance;
    o_pc_en      = advance & ~stall & ~fetch_stop & ~ID_haltflag;
    o_ifid_en    = advance & ~stall;
    o_idex_flush = advance & stall;
    o_ifid_flush = advance & ~stall & (i_branch_taken | ID_haltflag | fetch_stop);
    o_halted     = (state == ST_HALTED);
    o_state      = state;
  end

  // Fetch stop latches once a halt leaves ID; drain counts advances after it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      fetch_stop <= 1'b0;
      drain_cnt  <= DRAIN_ZERO;
    end else begin
      if (advance & ID_haltflag & ~stall) begin
        fetch_stop <= 1'b1;
      end else begin
        fetch_stop <= fetch_stop;
      end
      if (advance & fetch_stop & (drain_cnt != DRAIN_MAX)) begin
        drain_cnt <= drain_cnt + DRAIN_ONE;
      end else begin
        drain_cnt <= drain_cnt;
      end
    end
  end

`ifdef PIPE_CYCLE_COUNT_EN
  logic [31:0] cycle_count;

  // Saturating count of advanced cycles; no advance happens in HALTED.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cycle_count <= 32'd0;
    end else if (advance && (cycle_count != 32'hFFFF_FFFF)) begin
      cycle_count <= cycle_count + 32'd1;
    end else begin
      cycle_count <= cycle_count;
    end
  end

  assign o_cycle_count = cycle_count;
`else
  assign o_cycle_count = 32'd0;
`endif

endmodule
